// File: rtl/inst_pkg.sv
// Shared instruction types for the micro ARM core: ALU op codes, register
// index type, the PC index and the forwarding-port bundle.
package inst_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        ORR = 2'd3
    } alu_ctrl_t;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t REG_PC = 4'd15;

    // One in-flight result that may be forwarded to a consumer.
    typedef struct packed {
        logic        wen;
        reg_idx_t    rd;
        logic [31:0] val;
    } fwd_port_t;

endpackage

// File: rtl/operand_stage_fwd_mux.sv
// fwd_mux: resolves one source operand against the EX and WB result ports.
// With OPERAND_STAGE_FWD_EN defined the forwarded value is selected (EX
// before WB); otherwise the register-file value passes through and only the
// match flag is produced, for the interlock.
module fwd_mux
    import inst_pkg::*;
(
    input  reg_idx_t    src,
    input  logic        active,
    input  logic [31:0] rf_val,
    input  fwd_port_t   ex,
    input  fwd_port_t   wb,
    output logic [31:0] val,
    output logic        match
);

    logic ex_hit;
    logic wb_hit;

    // The PC is supplied by decode directly, so it never matches a writer.
    assign ex_hit = active && ex.wen && (ex.rd == src) && (src != REG_PC);
    assign wb_hit = active && wb.wen && (wb.rd == src) && (src != REG_PC);
    assign match  = ex_hit || wb_hit;

`ifdef OPERAND_STAGE_FWD_EN
    // EX is the younger result, so it wins over WB.
    always_comb begin
        val = rf_val;
        if (ex_hit)      val = ex.val;
        else if (wb_hit) val = wb.val;
    end
`else
    logic unused_fwd_val;
    assign unused_fwd_val = ^{ex.val, wb.val};
    assign val            = rf_val;
`endif

endmodule

// File: rtl/operand_stage.sv
// operand_stage: decode-to-execute pipeline register feeding the ALU.
// Resolves RAW hazards on rn/rm either by forwarding (OPERAND_STAGE_FWD_EN
// defined) or by holding in_ready low until the writer retires (default).
// Holds one instruction under a valid/ready handshake with stall and flush.
module operand_stage
    import inst_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rn_idx,
    input  logic [3:0]  in_rm_idx,
    input  logic [31:0] in_rn_val,
    input  logic [31:0] in_rm_val,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [1:0]  in_ctrl,
    input  logic [3:0]  in_rd,
    input  logic        in_wen,
    input  logic        flush,
    input  logic        fwd_ex_wen,
    input  logic [3:0]  fwd_ex_rd,
    input  logic [31:0] fwd_ex_val,
    input  logic        fwd_wb_wen,
    input  logic [3:0]  fwd_wb_rd,
    input  logic [31:0] fwd_wb_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [1:0]  out_ctrl,
    output logic [3:0]  out_rd,
    output logic        out_wen
);

    fwd_port_t   ex_port;
    fwd_port_t   wb_port;
    logic [31:0] rn_res;
    logic [31:0] rm_res;
    logic        rn_match;
    logic        rm_match;
    logic        hazard;
    logic        accept;

    assign ex_port = '{wen: fwd_ex_wen, rd: fwd_ex_rd, val: fwd_ex_val};
    assign wb_port = '{wen: fwd_wb_wen, rd: fwd_wb_rd, val: fwd_wb_val};

    fwd_mux u_rn_mux (
        .src    (in_rn_idx),
        .active (1'b1),
        .rf_val (in_rn_val),
        .ex     (ex_port),
        .wb     (wb_port),
        .val    (rn_res),
        .match  (rn_match)
    );

    // rm is only a source when operand b is not the immediate.
    fwd_mux u_rm_mux (
        .src    (in_rm_idx),
        .active (!in_use_imm),
        .rf_val (in_rm_val),
        .ex     (ex_port),
        .wb     (wb_port),
        .val    (rm_res),
        .match  (rm_match)
    );

`ifdef OPERAND_STAGE_FWD_EN
    logic unused_match;
    assign unused_match = rn_match ^ rm_match;
    assign hazard       = 1'b0;
`else
    assign hazard       = rn_match || rm_match;
`endif

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Pipeline register: flush beats capture, capture beats drain, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_ctrl  <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_wen   <= in_wen;
            out_a     <= rn_res;
            out_b     <= in_use_imm ? in_imm : rm_res;
            out_ctrl  <= in_ctrl;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: vector table for operand resolution,
// plus sequences for streaming, backpressure/flush and async reset.
module tb_operand_stage;
    import inst_pkg::*;

`ifdef OPERAND_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_rn_idx, in_rm_idx, in_rd;
    logic [31:0] in_rn_val, in_rm_val, in_imm;
    logic        in_use_imm, in_wen, flush;
    logic [1:0]  in_ctrl;
    logic        fwd_ex_wen, fwd_wb_wen;
    logic [3:0]  fwd_ex_rd, fwd_wb_rd;
    logic [31:0] fwd_ex_val, fwd_wb_val;
    logic        out_valid, out_ready, out_wen;
    logic [31:0] out_a, out_b;
    logic [1:0]  out_ctrl;
    logic [3:0]  out_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rn_idx(in_rn_idx), .in_rm_idx(in_rm_idx),
        .in_rn_val(in_rn_val), .in_rm_val(in_rm_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_ctrl(in_ctrl),
        .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
        .fwd_ex_wen(fwd_ex_wen), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_val(fwd_ex_val),
        .fwd_wb_wen(fwd_wb_wen), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_val(fwd_wb_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_wen(out_wen)
    );

    typedef struct {
        logic [3:0]  rn, rm;
        logic [31:0] rnv, rmv, imm;
        logic        use_imm;
        logic [1:0]  ctrl;
        logic [3:0]  rd;
        logic        wen;
        logic        exw;
        logic [3:0]  exr;
        logic [31:0] exv;
        logic        wbw;
        logic [3:0]  wbr;
        logic [31:0] wbv;
        logic        rdy;
        logic [31:0] a, b;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_fwd();
        fwd_ex_wen = 1'b0; fwd_ex_rd = 4'd0; fwd_ex_val = 32'd0;
        fwd_wb_wen = 1'b0; fwd_wb_rd = 4'd0; fwd_wb_val = 32'd0;
    endtask

    initial begin
        //        rn    rm    rnv          rmv          imm          ui    ctrl rd    wen   exw   exr    exv            wbw   wbr   wbv          rdy   a            b
        vt[0] = '{4'd1, 4'd0, 32'd5,       32'd0,       32'd7,       1'b1, ADD, 4'd1, 1'b1, 1'b0, 4'd0,  32'd0,         1'b0, 4'd0, 32'd0,       1'b1, 32'd5,       32'd7};
        vt[1] = '{4'd2, 4'd3, 32'h99,      32'h33,      32'd0,       1'b0, SUB, 4'd5, 1'b1, 1'b1, 4'd2,  32'h10,        1'b0, 4'd0, 32'd0,       FWD,  32'h10,      32'h33};
        vt[2] = '{4'd2, 4'd3, 32'h99,      32'h33,      32'd0,       1'b0, SUB, 4'd5, 1'b1, 1'b1, 4'd2,  32'h10,        1'b1, 4'd2, 32'h20,      FWD,  32'h10,      32'h33};
        vt[3] = '{4'd1, 4'd3, 32'h11,      32'h33,      32'd0,       1'b0, ORR, 4'd6, 1'b0, 1'b0, 4'd0,  32'd0,         1'b1, 4'd3, 32'h44,      FWD,  32'h11,      32'h44};
        vt[4] = '{4'd1, 4'd3, 32'h11,      32'h33,      32'h55,      1'b1, ORR, 4'd6, 1'b0, 1'b0, 4'd0,  32'd0,         1'b1, 4'd3, 32'h44,      1'b1, 32'h11,      32'h55};
        vt[5] = '{4'd15,4'd0, 32'h108,     32'd0,       32'd4,       1'b1, ADD, 4'd7, 1'b1, 1'b1, 4'd15, 32'hdead,      1'b0, 4'd0, 32'd0,       1'b1, 32'h108,     32'd4};
        vt[6] = '{4'd2, 4'd7, 32'h99,      32'h77,      32'd0,       1'b0, AND, 4'd8, 1'b1, 1'b0, 4'd2,  32'h10,        1'b0, 4'd7, 32'h70,      1'b1, 32'h99,      32'h77};
        vt[7] = '{4'd4, 4'd4, 32'h40,      32'h41,      32'd0,       1'b0, ADD, 4'd9, 1'b1, 1'b1, 4'd4,  32'hbb,        1'b1, 4'd4, 32'haa,      FWD,  32'hbb,      32'hbb};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_rn_idx = 4'd0; in_rm_idx = 4'd0; in_rn_val = 32'd0; in_rm_val = 32'd0;
        in_imm = 32'd0; in_use_imm = 1'b1; in_ctrl = ADD; in_rd = 4'd0; in_wen = 1'b0;
        clear_fwd();
        #12;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_wen",   {31'd0, out_wen},   32'd0);
        chk("reset out_a",     out_a,              32'd0);
        chk("reset out_b",     out_b,              32'd0);
        chk("reset out_ctrl",  {30'd0, out_ctrl},  32'd0);
        chk("reset out_rd",    {28'd0, out_rd},    32'd0);
        @(negedge clk); rst = 1'b0;

        // Operand resolution table, downstream always ready.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_rn_idx = vt[i].rn; in_rm_idx = vt[i].rm;
            in_rn_val = vt[i].rnv; in_rm_val = vt[i].rmv; in_imm = vt[i].imm;
            in_use_imm = vt[i].use_imm; in_ctrl = vt[i].ctrl;
            in_rd = vt[i].rd; in_wen = vt[i].wen;
            fwd_ex_wen = vt[i].exw; fwd_ex_rd = vt[i].exr; fwd_ex_val = vt[i].exv;
            fwd_wb_wen = vt[i].wbw; fwd_wb_rd = vt[i].wbr; fwd_wb_val = vt[i].wbv;
            in_valid = 1'b1; out_ready = 1'b1;
            #1 chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].rdy});
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].rdy});
            if (vt[i].rdy) begin
                chk($sformatf("vec%0d out_a", i),    out_a, vt[i].a);
                chk($sformatf("vec%0d out_b", i),    out_b, vt[i].b);
                chk($sformatf("vec%0d out_ctrl", i), {30'd0, out_ctrl}, {30'd0, vt[i].ctrl});
                chk($sformatf("vec%0d out_rd", i),   {28'd0, out_rd}, {28'd0, vt[i].rd});
                chk($sformatf("vec%0d out_wen", i),  {31'd0, out_wen}, {31'd0, vt[i].wen});
            end
        end

        // Streaming: four back-to-back ADDs, one result per cycle.
        @(negedge clk);
        clear_fwd();
        in_rn_idx = 4'd1; in_use_imm = 1'b1; in_imm = 32'd7; in_ctrl = ADD;
        in_rd = 4'd1; in_wen = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            in_rn_val = 32'd5 + 32'(k);
            @(posedge clk); #1;
            chk($sformatf("stream%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stream%0d out_a", k), out_a, 32'd5 + 32'(k));
            chk($sformatf("stream%0d out_b", k), out_b, 32'd7);
            chk($sformatf("stream%0d out_ctrl", k), {30'd0, out_ctrl}, {30'd0, ADD});
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure for three cycles, then flush with a pending input.
        @(negedge clk);
        in_valid = 1'b1; in_rn_val = 32'h123; in_rd = 4'd9; in_wen = 1'b1;
        @(posedge clk); #1;
        chk("bp capture out_a", out_a, 32'h123);
        @(negedge clk);
        out_ready = 1'b0; in_rn_val = 32'h456; in_rd = 4'd3;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d out_a", k), out_a, 32'h123);
            chk($sformatf("bp%0d out_rd", k), {28'd0, out_rd}, 32'd9);
            @(negedge clk);
        end
        flush = 1'b1;
        #1 chk("flush in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush out_wen", {31'd0, out_wen}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post-flush out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle with the stage full.
        @(negedge clk);
        in_valid = 1'b1; in_rn_val = 32'h777; in_imm = 32'h9;
        @(posedge clk); #1;
        chk("prerst out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst out_a", out_a, 32'd0);
        chk("async rst out_b", out_b, 32'd0);
        chk("async rst out_wen", {31'd0, out_wen}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("after rst empty", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
